// File: rtl/hcsr04_multi_ctrl.sv
// Round-robin controller for CHANNELS HC-SR04 sensors: triggers each in turn,
// measures echo width in cm per channel, with timeout flags and periodic mode.
module hcsr04_multi_ctrl #(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned DIST_WIDTH     = 9,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CM_CYCLES      = 2941,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned PERIOD_CYCLES  = 5000000,
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           medir,
  input  logic                           continuo,
  input  logic [CHANNELS-1:0]            echo,
  output logic [CHANNELS-1:0]            trigger,
  output logic [CHANNELS*DIST_WIDTH-1:0] medida,
  output logic [CHANNELS-1:0]            timeout,
  output logic [CW-1:0]                  canal,
  output logic                           ocupado,
  output logic                           pronto,
  output logic [3:0]                     db_estado
);

  localparam int unsigned TRW = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SCW = $clog2(CM_CYCLES + 1);
  localparam int unsigned PEW = $clog2(PERIOD_CYCLES + 1);
  localparam logic [DIST_WIDTH-1:0] CM_MAX = {{(DIST_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_TRIG     = 4'd1,
    ST_ESPERA   = 4'd2,
    ST_MEDE     = 4'd3,
    ST_ARMAZENA = 4'd4,
    ST_FIM      = 4'd5,
    ST_PAUSA    = 4'd6,
    ST_TMO      = 4'd7
  } state_t;

  state_t                state, state_n;
  logic [CHANNELS-1:0]   echo_s1, echo_s2;
  logic                  medir_q, start_r;
  logic [CW-1:0]         canal_r;
  logic [TRW-1:0]        trig_cnt;
  logic [TOW-1:0]        to_cnt;
  logic [SCW-1:0]        sub_cnt;
  logic [DIST_WIDTH-1:0] cm;
  logic [PEW-1:0]        per_cnt;
  logic                  to_flag;
  logic                  echo_sync, to_last, trig_last, per_done, last_ch;
  logic                  round_start, next_ch, count_en, to_hit, store;

  assign echo_sync = echo_s2[canal_r];
  assign to_last   = (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
  assign trig_last = (trig_cnt == TRW'(TRIG_CYCLES - 1));
  assign per_done  = (per_cnt == PEW'(PERIOD_CYCLES - 1));
  assign last_ch   = (canal_r == CW'(CHANNELS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    round_start = 1'b0;
    next_ch     = 1'b0;
    count_en    = 1'b0;
    to_hit      = 1'b0;
    store       = 1'b0;
    case (state)
      ST_IDLE:
        if (start_r || continuo) begin
          state_n     = ST_TRIG;
          round_start = 1'b1;
        end
      ST_TRIG:
        if (trig_last) state_n = ST_ESPERA;
      // The cycle that first sees echo high is counted so the width is exact
      ST_ESPERA:
        if (to_last) begin
          to_hit  = 1'b1;
          state_n = ST_TMO;
        end else if (echo_sync) begin
          count_en = 1'b1;
          state_n  = ST_MEDE;
        end
      ST_MEDE:
        if (to_last) begin
          to_hit  = 1'b1;
          state_n = ST_TMO;
        end else if (echo_sync) begin
          count_en = 1'b1;
        end else begin
          state_n = ST_ARMAZENA;
        end
      ST_ARMAZENA: begin
        store = 1'b1;
        if (!last_ch) begin
          next_ch = 1'b1;
          state_n = ST_TRIG;
        end else begin
          state_n = ST_FIM;
        end
      end
      ST_FIM:
        state_n = continuo ? ST_PAUSA : ST_IDLE;
      ST_PAUSA:
        if (!continuo) begin
          state_n = ST_IDLE;
        end else if (per_done) begin
          state_n     = ST_TRIG;
          round_start = 1'b1;
        end
      ST_TMO:
        state_n = ST_ARMAZENA;
      default:
        state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    trigger = '0;
    if (state == ST_TRIG) trigger[canal_r] = 1'b1;
    ocupado   = (state != ST_IDLE);
    pronto    = (state == ST_FIM);
    db_estado = state;
    canal     = canal_r;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_s1  <= '0;
      echo_s2  <= '0;
      medir_q  <= 1'b0;
      start_r  <= 1'b0;
      canal_r  <= '0;
      trig_cnt <= '0;
      to_cnt   <= '0;
      sub_cnt  <= '0;
      cm       <= '0;
      per_cnt  <= '0;
      to_flag  <= 1'b0;
      medida   <= '0;
      timeout  <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      medir_q <= medir;
      start_r <= medir & ~medir_q;

      if (round_start)    canal_r <= '0;
      else if (next_ch)   canal_r <= canal_r + 1'b1;

      // Period counter saturates so an overlong round leaves PAUSA at once
      if (round_start)    per_cnt <= '0;
      else if (!per_done) per_cnt <= per_cnt + 1'b1;

      if (state == ST_TRIG) trig_cnt <= trig_last ? '0 : trig_cnt + 1'b1;

      if (state == ST_ESPERA || state == ST_MEDE) to_cnt <= to_cnt + 1'b1;
      else                                        to_cnt <= '0;

      if (state == ST_TRIG) begin
        sub_cnt <= '0;
        cm      <= '0;
        to_flag <= 1'b0;
      end else if (count_en) begin
        if (sub_cnt == SCW'(CM_CYCLES - 1)) begin
          sub_cnt <= '0;
          if (cm != CM_MAX) cm <= cm + 1'b1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end

      if (to_hit) begin
        to_flag                                     <= 1'b1;
        medida[canal_r*DIST_WIDTH +: DIST_WIDTH]    <= '1;
        timeout[canal_r]                            <= 1'b1;
      end else if (store && !to_flag) begin
        medida[canal_r*DIST_WIDTH +: DIST_WIDTH]    <= cm;
        timeout[canal_r]                            <= 1'b0;
      end
    end
  end

endmodule
